sccomp_run_monitor: RTL and testbench

Synthesizable run-control and register-dump monitor for the single-cycle MIPS computer (sccomp). It watches the CPU's PC each cycle and ends the run on one of three conditions: halt PC reached, cycle budget exhausted, or invalid PC. It then walks the register file through the existing reg_sel/reg_data debug port and streams every register out over a valid/ready interface. This generalises the bench-only halt/timeout/dump logic into a parametrised block usable on FPGA and in simulation.

---
 rtl/sccomp_run_monitor_if.sv | 28 ++
 rtl/sccomp_run_monitor.sv | 142 ++++++++++++++
 tb/tb_sccomp_run_monitor.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/sccomp_run_monitor_if.sv
// Dump stream bundle for sccomp_run_monitor.
// One register word per transfer, valid/ready handshake.
interface sccomp_run_monitor_if #(
  parameter int SEL_W  = 5,
  parameter int DATA_W = 32
);
  logic              dump_valid;
  logic              dump_ready;
  logic [SEL_W-1:0]  dump_idx;
  logic [DATA_W-1:0] dump_data;
  logic              dump_last;

  modport master (
    output dump_valid,
    output dump_idx,
    output dump_data,
    output dump_last,
    input  dump_ready
  );

  modport slave (
    input  dump_valid,
    input  dump_idx,
    input  dump_data,
    input  dump_last,
    output dump_ready
  );
endinterface

// File: rtl/sccomp_run_monitor.sv
// Run-control and register-dump monitor for sccomp.
// Ends a run on halt/timeout/bad PC, then streams the regfile.
module sccomp_run_monitor #(
  parameter int              PC_W       = 32,
  parameter logic [PC_W-1:0] HALT_PC    = 32'h00000048,
  parameter int              MAX_CYCLES = 1000,
  parameter int              CNT_W      = 16,
  parameter int              NREG       = 32,
  parameter int              SEL_W      = 5,
  parameter int              DATA_W     = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [PC_W-1:0]     pc,
  input  logic                pc_valid,
  output logic [SEL_W-1:0]    reg_sel,
  input  logic [DATA_W-1:0]   reg_data,
  sccomp_run_monitor_if.master dump,
  output logic                running,
  output logic                done,
  output logic [CNT_W-1:0]    cycle_count,
  output logic [1:0]          status
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DSEL,
    S_DOUT,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(MAX_CYCLES - 1);
  localparam logic [SEL_W-1:0] LAST_REG = SEL_W'(NREG - 1);

  localparam logic [1:0] ST_NONE  = 2'b00;
  localparam logic [1:0] ST_HALT  = 2'b01;
  localparam logic [1:0] ST_TMO   = 2'b10;
  localparam logic [1:0] ST_BADPC = 2'b11;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              valid_q, valid_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [1:0]        status_q, status_d;

  // Next-state: run supervision, then select/present each register.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    valid_d  = valid_q;
    idx_d    = idx_q;
    data_d   = data_q;
    last_d   = last_q;
    cyc_d    = cyc_q;
    status_d = status_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_RUN;
          cyc_d    = '0;
          status_d = ST_NONE;
        end
      end
      S_RUN: begin
        if (!pc_valid) begin
          status_d = ST_BADPC;
          state_d  = S_DSEL;
          sel_d    = '0;
        end else if (pc == HALT_PC) begin
          status_d = ST_HALT;
          state_d  = S_DSEL;
          sel_d    = '0;
        end else if (cyc_q == LAST_CYC) begin
          status_d = ST_TMO;
          state_d  = S_DSEL;
          sel_d    = '0;
        end else begin
          cyc_d = cyc_q + CNT_W'(1);
        end
      end
      S_DSEL: begin
        data_d  = (sel_q == '0) ? '0 : reg_data;
        idx_d   = sel_q;
        last_d  = (sel_q == LAST_REG);
        valid_d = 1'b1;
        state_d = S_DOUT;
      end
      S_DOUT: begin
        if (dump.dump_ready) begin
          valid_d = 1'b0;
          if (last_q) begin
            state_d = S_DONE;
            sel_d   = '0;
          end else begin
            sel_d   = sel_q + SEL_W'(1);
            state_d = S_DSEL;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
      cyc_q    <= '0;
      status_q <= ST_NONE;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      last_q   <= last_d;
      cyc_q    <= cyc_d;
      status_q <= status_d;
    end
  end

  assign reg_sel         = sel_q;
  assign dump.dump_valid = valid_q;
  assign dump.dump_idx   = idx_q;
  assign dump.dump_data  = data_q;
  assign dump.dump_last  = last_q;
  assign running         = (state_q == S_RUN);
  assign done            = (state_q == S_DONE);
  assign cycle_count     = cyc_q;
  assign status          = status_q;

endmodule

// File: tb/tb_sccomp_run_monitor.sv
// Directed bench for sccomp_run_monitor.
// Instance a: default budget; instance b: MAX_CYCLES=10.
module tb_sccomp_run_monitor;

  logic        clk;
  logic        rstn;
  logic        start_a;
  logic        start_b;
  logic [31:0] pc;
  logic        pcv;
  logic        rdy;
  logic        use_b;

  logic [4:0]  sel_a, sel_b;
  logic [31:0] rd_a, rd_b;
  logic        run_a, run_b, done_a, done_b;
  logic [15:0] cnt_a, cnt_b;
  logic [1:0]  st_a, st_b;

  int vectors;
  int miscompares;

  sccomp_run_monitor_if #(.SEL_W(5), .DATA_W(32)) ifa ();
  sccomp_run_monitor_if #(.SEL_W(5), .DATA_W(32)) ifb ();

  function automatic logic [31:0] rv(input logic [4:0] s);
    logic [31:0] w;
    w = {27'b0, s};
    return 32'hC0DE0000 | (w << 8) | w;
  endfunction

  assign rd_a = rv(sel_a);
  assign rd_b = rv(sel_b);
  assign ifa.dump_ready = rdy;
  assign ifb.dump_ready = rdy;

  sccomp_run_monitor dut_a (
    .clk(clk), .rstn(rstn), .start(start_a),
    .pc(pc), .pc_valid(pcv),
    .reg_sel(sel_a), .reg_data(rd_a),
    .dump(ifa),
    .running(run_a), .done(done_a),
    .cycle_count(cnt_a), .status(st_a)
  );

  sccomp_run_monitor #(.MAX_CYCLES(10)) dut_b (
    .clk(clk), .rstn(rstn), .start(start_b),
    .pc(pc), .pc_valid(pcv),
    .reg_sel(sel_b), .reg_data(rd_b),
    .dump(ifb),
    .running(run_b), .done(done_b),
    .cycle_count(cnt_b), .status(st_b)
  );

  wire        m_valid = use_b ? ifb.dump_valid : ifa.dump_valid;
  wire [4:0]  m_idx   = use_b ? ifb.dump_idx   : ifa.dump_idx;
  wire [31:0] m_data  = use_b ? ifb.dump_data  : ifa.dump_data;
  wire        m_last  = use_b ? ifb.dump_last  : ifa.dump_last;
  wire [4:0]  m_sel   = use_b ? sel_b  : sel_a;
  wire        m_run   = use_b ? run_b  : run_a;
  wire        m_done  = use_b ? done_b : done_a;
  wire [15:0] m_cnt   = use_b ? cnt_b  : cnt_a;
  wire [1:0]  m_st    = use_b ? st_b   : st_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"},  m_valid, 0);
    chk({tag, ".idx"},    m_idx,   0);
    chk({tag, ".data"},   m_data,  0);
    chk({tag, ".last"},   m_last,  0);
    chk({tag, ".sel"},    m_sel,   0);
    chk({tag, ".run"},    m_run,   0);
    chk({tag, ".done"},   m_done,  0);
    chk({tag, ".cnt"},    m_cnt,   0);
    chk({tag, ".status"}, m_st,    0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_a_halt(input logic [15:0] ecnt);
    use_b = 1'b0;
    pc = 32'h0;
    pcv = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("run.running", m_run, 1);
    chk("run.cnt0", m_cnt, 0);
    chk("run.status0", m_st, 0);
    chk("run.done0", m_done, 0);
    for (int k = 0; k < 40; k++) begin
      if (!m_run) break;
      tick();
      pc = pc + 32'd4;
    end
    chk("halt.ended", m_run, 0);
    chk("halt.status", m_st, 2'b01);
    chk("halt.cnt", m_cnt, ecnt);
    chk("halt.sel0", m_sel, 0);
  endtask

  task automatic collect(input int stall_idx, input int abort_idx);
    int n;
    logic [31:0] ed;
    for (int i = 0; i < 32; i++) begin
      n = 0;
      while (!m_valid && n < 8) begin
        tick();
        n++;
      end
      chk("dump.valid", m_valid, 1);
      if (!m_valid) return;
      ed = (i == 0) ? 32'h0 : rv(5'(i));
      chk("dump.idx", m_idx, i);
      chk("dump.data", m_data, ed);
      chk("dump.last", m_last, (i == 31));
      if (i == abort_idx) begin
        rdy = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        chk_zero("midreset");
        return;
      end
      if (i == stall_idx) begin
        rdy = 1'b0;
        repeat (5) begin
          tick();
          chk("stall.valid", m_valid, 1);
          chk("stall.idx", m_idx, i);
          chk("stall.data", m_data, ed);
          chk("stall.sel", m_sel, i);
        end
        rdy = 1'b1;
      end
      tick();
      chk("dump.accepted", m_valid, 0);
    end
    chk("dump.done", m_done, 1);
    chk("dump.sel_end", m_sel, 0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rstn = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    pc = 32'h0;
    pcv = 1'b1;
    rdy = 1'b1;
    use_b = 1'b0;
    #1;
    chk_zero("reset_a");
    use_b = 1'b1;
    chk_zero("reset_b");
    use_b = 1'b0;
    tick();
    rstn = 1'b1;
    tick();

    // Halt run with a 5-cycle stall on index 7.
    run_a_halt(16'd18);
    collect(7, -1);

    // Restart from DONE with bad PC at the halt address.
    pc = 32'h48;
    pcv = 1'b0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("restart.status", m_st, 0);
    chk("restart.done", m_done, 0);
    chk("restart.running", m_run, 1);
    tick();
    chk("prio.status", m_st, 2'b11);
    chk("prio.cnt", m_cnt, 0);
    chk("prio.running", m_run, 0);
    collect(-1, -1);
    pcv = 1'b1;

    // Second halt run reproduces the first.
    run_a_halt(16'd18);
    collect(-1, -1);

    // Timeout on instance b, pc held at 0.
    use_b = 1'b1;
    pc = 32'h0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("tmo.running", m_run, 1);
    for (int k = 0; k < 40; k++) begin
      if (!m_run) break;
      tick();
    end
    chk("tmo.ended", m_run, 0);
    chk("tmo.status", m_st, 2'b10);
    chk("tmo.cnt", m_cnt, 9);
    collect(-1, -1);
    use_b = 1'b0;

    // Reset during presentation of index 12.
    run_a_halt(16'd18);
    collect(-1, 12);
    tick();
    chk_zero("held_reset");
    rstn = 1'b1;
    rdy = 1'b1;
    tick();
    chk("post_reset.valid", m_valid, 0);

    // Fresh run after reset.
    run_a_halt(16'd18);
    collect(-1, -1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
